axil_bram8_ctrl: RTL and testbench
==================================

Name: axil_bram8_ctrl

Overview:
AXI4-Lite slave controller that sequences the 256x8 byte BRAM, which reads and writes on the falling clock edge. It shares the single BRAM port between the AXI write channel and the AXI read channel using a 2-way round-robin scheme. Each 32-bit-aligned AXI word maps to one BRAM byte. A top-level wrapper instantiates this controller next to the BRAM.

Parameters:
ADDR_WIDTH, 12, AXI address width; byte address; word index = addr[9:2].
MEM_AW, 8, BRAM address width (256 entries).

Ports:
clk  in  1  system clock; BRAM shares it.
rst_n  in  1  synchronous, active-low reset.
s_axi_awaddr  in  ADDR_WIDTH  write address.
s_axi_awvalid  in  1  write-address valid.
s_axi_awready  out  1  write-address ready.
s_axi_wdata  in  32  write data; only [7:0] is used.
s_axi_wstrb  in  4  byte strobes; only [0] is used.
s_axi_wvalid  in  1  write-data valid.
s_axi_wready  out  1  write-data ready.
s_axi_bresp  out  2  write response.
s_axi_bvalid  out  1  write-response valid.
s_axi_bready  in  1  write-response ready.
s_axi_araddr  in  ADDR_WIDTH  read address.
s_axi_arvalid  in  1  read-address valid.
s_axi_arready  out  1  read-address ready.
s_axi_rdata  out  32  read data; {24'h0, byte}.
s_axi_rresp  out  2  read response.
s_axi_rvalid  out  1  read-data valid.
s_axi_rready  in  1  read-data ready.
bram_we  out  1  BRAM write enable.
bram_addr  out  8  BRAM address.
bram_din  out  8  BRAM write data.
bram_dout  in  8  BRAM read data; valid at the posedge after bram_addr is driven.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values (rst_n low at a posedge, any state):
  - state goes to IDLE; aw_held, w_held cleared.
  - bvalid, rvalid, bram_we = 0; bresp, rresp, rdata, bram_addr, bram_din = 0.
  - last_grant = READ, so the first tie goes to the write.
  - awready, wready, arready are forced 0 while rst_n is low.
  - Reset mid-transaction drops the transaction silently; no response is issued.
- AW/W capture:
  - awready = !aw_held; wready = !w_held. Both are independent of state.
  - On a handshake, latch the address/data/strobe and set the matching held flag.
  - AW and W may arrive in either order or in the same cycle.
- States:
  - IDLE: wr_cand = aw_held & w_held; rd_cand = arvalid.
    - Only wr_cand -> go to WR_EXEC.
    - Only rd_cand -> arready = 1 (combinational), go to RD_ADDR.
    - Both -> grant the one opposite last_grant; arready = 0 if the write wins.
    - The granted side updates last_grant.
  - WR_EXEC (1 cycle):
    - Drive bram_addr = awaddr[9:2], bram_din = wdata[7:0].
    - bram_we = wstrb[0] & in_range.
    - Clear both held flags; go to WR_RESP.
  - WR_RESP: bvalid = 1; bresp = OKAY if in range, else SLVERR. Hold until bready; then go to IDLE.
  - RD_ADDR (1 cycle): drive bram_addr = araddr[9:2], bram_we = 0.
    - At the next posedge, rdata <= in_range ? {24'h0, bram_dout} : 0.
    - rresp <= OKAY or SLVERR; go to RD_RESP.
  - RD_RESP: rvalid = 1; hold rdata and rresp stable until rready; then go to IDLE.
- Range check: in_range = (addr[ADDR_WIDTH-1:10] == 0).
  - Out-of-range write: no BRAM write, bresp = SLVERR.
  - Out-of-range read: rdata = 0, rresp = SLVERR.
- Ignored inputs: addr[1:0] and wstrb[3:1].
- Strobe gating: wstrb[0] = 0 -> no BRAM write, bresp = OKAY.
- Latency:
  - Read: AR handshake at edge T0 -> rvalid high from T1.
  - Write: both held by edge T0, and the write wins arbitration -> bram_we during T1..T2, bvalid from T2.
- Overlap: only one BRAM access is in flight at a time. A new AW or W may be captured during any state; it waits for IDLE.
- Response backpressure: bvalid/rvalid stay high indefinitely without bready/rready; no further accesses are granted meanwhile.

Decomposition:
- Package axil_bram_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - State enum {IDLE, WR_EXEC, WR_RESP, RD_ADDR, RD_RESP}.
  - Grant enum {GNT_READ, GNT_WRITE}.
  - WORD_LSB = 2.
- Sub-module: axil_rr_arb2. Inputs wr_cand, rd_cand, en; outputs gnt_wr, gnt_rd. It holds the last_grant register.

Test Plan:
- Reset, then AR 0x008 -> rvalid one cycle after AR, rdata = 0x000000B2 (BRAM init byte 2), rresp = OKAY.
- AW 0x030 two cycles before W data 0x000000A5, wstrb = 0x1 -> bvalid with OKAY; then AR 0x030 -> rdata = 0x000000A5.
- Write 0x004 with wstrb = 0x0 and data 0x11 -> bresp = OKAY; read 0x004 returns 0x0000007F (unchanged).
- Write to 0x400 -> bresp = SLVERR, bram_we never asserted; read 0x7FC -> rdata = 0, rresp = SLVERR.
- Write and read both pending in the same IDLE cycle, repeated three times after reset -> grants go write, read, write.
- Hold rready = 0 for 5 cycles -> rvalid and rdata stable, no new grant. Assert rst_n = 0 mid-RD_RESP -> rvalid = 0 at the next edge and all readies low.

Source files
------------

// File: rtl/axil_bram_pkg.sv
// Shared types and constants for the AXI4-Lite byte-BRAM controller.
package axil_bram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int unsigned WORD_LSB   = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_EXEC,
        WR_RESP,
        RD_ADDR,
        RD_RESP
    } state_e;

    typedef enum logic {
        GNT_READ,
        GNT_WRITE
    } grant_e;

endpackage

// File: rtl/axil_bram8_ctrl_arb.sv
// Two-way round-robin arbiter between the write and read channels.
module axil_rr_arb2
    import axil_bram_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic wr_cand,
    input  logic rd_cand,
    input  logic en,
    output logic gnt_wr,
    output logic gnt_rd
);

    grant_e r_last_grant;

    // On a tie the side that did not win last time gets the port.
    always_comb begin
        gnt_wr = en & wr_cand & (~rd_cand | (r_last_grant == GNT_READ));
        gnt_rd = en & rd_cand & (~wr_cand | (r_last_grant == GNT_WRITE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= GNT_READ;
        end else if (gnt_wr) begin
            r_last_grant <= GNT_WRITE;
        end else if (gnt_rd) begin
            r_last_grant <= GNT_READ;
        end
    end

endmodule

// File: rtl/axil_bram8_ctrl.sv
// AXI4-Lite slave sequencing a 256x8 falling-edge BRAM; one 32-bit word maps to one byte.
module axil_bram8_ctrl
    import axil_bram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned MEM_AW     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  bram_we,
    output logic [MEM_AW-1:0]     bram_addr,
    output logic [7:0]            bram_din,
    input  logic [7:0]            bram_dout
);

    state_e              r_state;
    logic                r_aw_held, r_w_held;
    logic [MEM_AW-1:0]   r_aw_idx;
    logic                r_aw_in_range;
    logic [7:0]          r_wdata;
    logic                r_wstrb0;
    logic                r_rd_in_range;
    logic                r_bvalid, r_rvalid, r_bram_we;
    logic [1:0]          r_bresp, r_rresp;
    logic [7:0]          r_rdata, r_bram_din;
    logic [MEM_AW-1:0]   r_bram_addr;

    logic w_gnt_wr, w_gnt_rd, w_arb_en;
    logic w_aw_in_range, w_ar_in_range;
    logic w_unused_bits;

    assign w_aw_in_range = (s_axi_awaddr[ADDR_WIDTH-1:10] == '0);
    assign w_ar_in_range = (s_axi_araddr[ADDR_WIDTH-1:10] == '0);
    assign w_arb_en      = rst_n & (r_state == IDLE);
    assign w_unused_bits = ^{s_axi_wdata[31:8], s_axi_wstrb[3:1], s_axi_awaddr[1:0],
                             s_axi_araddr[1:0]};

    axil_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_cand (r_aw_held & r_w_held),
        .rd_cand (s_axi_arvalid),
        .en      (w_arb_en),
        .gnt_wr  (w_gnt_wr),
        .gnt_rd  (w_gnt_rd)
    );

    assign s_axi_awready = rst_n & ~r_aw_held;
    assign s_axi_wready  = rst_n & ~r_w_held;
    assign s_axi_arready = w_gnt_rd;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = {24'h0, r_rdata};
    assign bram_we       = r_bram_we;
    assign bram_addr     = r_bram_addr;
    assign bram_din      = r_bram_din;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_aw_held     <= 1'b0;
            r_w_held      <= 1'b0;
            r_aw_idx      <= '0;
            r_aw_in_range <= 1'b0;
            r_wdata       <= '0;
            r_wstrb0      <= 1'b0;
            r_rd_in_range <= 1'b0;
            r_bvalid      <= 1'b0;
            r_rvalid      <= 1'b0;
            r_bram_we     <= 1'b0;
            r_bresp       <= RESP_OKAY;
            r_rresp       <= RESP_OKAY;
            r_rdata       <= '0;
            r_bram_addr   <= '0;
            r_bram_din    <= '0;
        end else begin
            // Capture runs in every state; held flags only clear in WR_EXEC.
            if (s_axi_awvalid && !r_aw_held) begin
                r_aw_idx      <= s_axi_awaddr[WORD_LSB +: MEM_AW];
                r_aw_in_range <= w_aw_in_range;
                r_aw_held     <= 1'b1;
            end
            if (s_axi_wvalid && !r_w_held) begin
                r_wdata  <= s_axi_wdata[7:0];
                r_wstrb0 <= s_axi_wstrb[0];
                r_w_held <= 1'b1;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_gnt_wr) begin
                        r_bram_addr <= r_aw_idx;
                        r_bram_din  <= r_wdata;
                        r_bram_we   <= r_wstrb0 & r_aw_in_range;
                        r_state     <= WR_EXEC;
                    end else if (w_gnt_rd) begin
                        r_bram_addr   <= s_axi_araddr[WORD_LSB +: MEM_AW];
                        r_bram_we     <= 1'b0;
                        r_rd_in_range <= w_ar_in_range;
                        r_state       <= RD_ADDR;
                    end
                end
                WR_EXEC: begin
                    r_bram_we <= 1'b0;
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    r_bvalid  <= 1'b1;
                    r_bresp   <= r_aw_in_range ? RESP_OKAY : RESP_SLVERR;
                    r_state   <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                // BRAM updates bram_dout on the falling edge inside this cycle.
                RD_ADDR: begin
                    r_rdata  <= r_rd_in_range ? bram_dout : 8'h00;
                    r_rresp  <= r_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    r_rvalid <= 1'b1;
                    r_state  <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_bram8_ctrl.sv
// Directed bench for axil_bram8_ctrl with a falling-edge 256x8 BRAM model.
module tb_axil_bram8_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] s_axi_awaddr, s_axi_araddr;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic        s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;
    logic        bram_we;
    logic [7:0]  bram_addr, bram_din;
    logic [7:0]  bram_dout = 8'h00;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    logic [7:0] mem [256];
    bit mem_ready = 1'b0;

    always #5 clk = ~clk;

    axil_bram8_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .bram_dout     (bram_dout)
    );

    // BRAM model: read-first, both ports act on the falling edge.
    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hB0;
            mem[1] = 8'h7F;
            mem_ready = 1'b1;
        end
        bram_dout = mem[bram_addr];
        if (bram_we) mem[bram_addr] = bram_din;
        if (bram_we) we_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string tag);
        int n;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
        check({tag, "_arready"}, 32'(s_axi_arready), 32'd1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check({tag, "_rvalid_t0"}, 32'(s_axi_rvalid), 32'd0);
        @(negedge clk);
        check({tag, "_rvalid_t1"}, 32'(s_axi_rvalid), 32'd1);
        check({tag, "_rdata"}, s_axi_rdata, exp_data);
        check({tag, "_rresp"}, 32'(s_axi_rresp), 32'(exp_resp));
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        check({tag, "_rvalid_done"}, 32'(s_axi_rvalid), 32'd0);
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int gap,
                             input logic [1:0] exp_resp, input int exp_we, input string tag);
        int n;
        int we0;
        we0 = we_cnt;
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = (gap == 0);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        if (gap > 0) begin
            s_axi_wvalid = 1'b0;
            repeat (gap - 1) @(negedge clk);
            s_axi_wvalid = 1'b1;
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
        check({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd1);
        check({tag, "_bresp"}, 32'(s_axi_bresp), 32'(exp_resp));
        check({tag, "_we_count"}, 32'(we_cnt - we0), 32'(exp_we));
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check({tag, "_bvalid_done"}, 32'(s_axi_bvalid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b1;
        s_axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_wready", 32'(s_axi_wready), 32'd0);
        check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("rst_bram_we", 32'(bram_we), 32'd0);
        check("rst_bram_addr", 32'(bram_addr), 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        s_axi_arvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_awready", 32'(s_axi_awready), 32'd1);
        check("idle_wready", 32'(s_axi_wready), 32'd1);

        axi_read(12'h008, 32'h0000_00B2, 2'b00, "rd_init2");
        axi_write(12'h030, 32'h0000_00A5, 4'h1, 2, 2'b00, 1, "wr_a5");
        axi_read(12'h030, 32'h0000_00A5, 2'b00, "rd_a5");
        axi_write(12'h004, 32'h0000_0011, 4'h0, 0, 2'b00, 0, "wr_nostrb");
        axi_read(12'h004, 32'h0000_007F, 2'b00, "rd_nostrb");
        axi_write(12'h400, 32'h0000_0033, 4'h1, 0, 2'b10, 0, "wr_oor");
        axi_read(12'h7FC, 32'h0000_0000, 2'b10, "rd_oor");

        // Three ties after reset: write, then read, then write.
        do_reset();
        s_axi_awaddr = 12'h010; s_axi_wdata = 32'h5C; s_axi_wstrb = 4'h1;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_araddr = 12'h010; s_axi_arvalid = 1'b1;
        #1;
        check("tie1_arready", 32'(s_axi_arready), 32'd0);
        @(negedge clk);
        s_axi_awaddr = 12'h014; s_axi_wdata = 32'h6D;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("tie1_bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        #1;
        check("tie2_arready", 32'(s_axi_arready), 32'd1);
        @(negedge clk);
        s_axi_araddr = 12'h014;
        @(negedge clk);
        check("tie2_rvalid", 32'(s_axi_rvalid), 32'd1);
        check("tie2_rdata", s_axi_rdata, 32'h5C);
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        #1;
        check("tie3_arready", 32'(s_axi_arready), 32'd0);
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
        check("tie3_bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        #1;
        n = 0;
        while (!s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        check("tie3_rdata", s_axi_rdata, 32'h6D);
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;

        // Read response backpressure with a write waiting, then reset mid-response.
        s_axi_araddr = 12'h008; s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        s_axi_awaddr = 12'h020; s_axi_wdata = 32'h99; s_axi_wstrb = 4'h1;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = we_cnt;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid", 32'(s_axi_rvalid), 32'd1);
            check("bp_rdata", s_axi_rdata, 32'hB2);
            check("bp_bvalid", 32'(s_axi_bvalid), 32'd0);
            @(negedge clk);
        end
        check("bp_no_write", 32'(we_cnt - n), 32'd0);
        rst_n = 1'b0;
        s_axi_arvalid = 1'b1;
        #1;
        check("mid_rst_arready", 32'(s_axi_arready), 32'd0);
        check("mid_rst_awready", 32'(s_axi_awready), 32'd0);
        check("mid_rst_wready", 32'(s_axi_wready), 32'd0);
        @(negedge clk);
        check("mid_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        s_axi_arvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
